// File: rtl/ddr_deserializer.sv
// DDR bit-pair deserializer: hunts for SYNC_WORD at either bit phase, then
// emits FRAME_LEN payload bytes on a registered strobe and resumes hunting.
module ddr_deserializer #(
    parameter logic [7:0] SYNC_WORD = 8'hA5,
    parameter int         FRAME_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       d_rise,
    input  logic       d_fall,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       sof,
    output logic       frame_done,
    output logic       locked
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t      state_q, state_d;
    logic [6:0]  hist_q, hist_d;
    logic [2:0]  hvalid_q, hvalid_d;
    logic [1:0]  pair_q, pair_d;
    logic [7:0]  byte_q, byte_d;
    logic        phase_q, phase_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        sof_q, sof_d;
    logic        done_q, done_d;

    // Only seven history bits need storing: the windows are taken from the
    // 9-bit post-shift view, whose top two bits come from the stored seven.
    logic [8:0]  hist_w;
    logic [7:0]  odd_win, even_win;
    logic        odd_hit, even_hit;

    assign hist_w   = {hist_q, d_rise, d_fall};
    assign odd_win  = hist_w[8:1];
    assign even_win = hist_w[7:0];

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        hvalid_d    = hvalid_q;
        pair_d      = pair_q;
        byte_d      = byte_q;
        phase_d     = phase_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        sof_d       = 1'b0;
        done_d      = 1'b0;
        odd_hit     = 1'b0;
        even_hit    = 1'b0;

        if (in_valid) begin
            hist_d = hist_w[6:0];
            unique case (state_q)
                HUNT: begin
                    hvalid_d = (hvalid_q == 3'd5) ? 3'd5 : hvalid_q + 3'd1;
                    odd_hit  = (hvalid_d == 3'd5) && (odd_win == SYNC_WORD);
                    even_hit = (hvalid_d >= 3'd4) && (even_win == SYNC_WORD);
                    if (odd_hit || even_hit) begin
                        // odd window holds the earlier-in-time alignment
                        phase_d = odd_hit;
                        pair_d  = 2'd0;
                        byte_d  = 8'd0;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    pair_d = pair_q + 2'd1;
                    if (pair_q == 2'd3) begin
                        out_valid_d = 1'b1;
                        out_data_d  = phase_q ? odd_win : even_win;
                        sof_d       = (byte_q == 8'd0);
                        done_d      = (byte_q == LAST_IDX);
                        byte_d      = byte_q + 8'd1;
                        if (byte_q == LAST_IDX) begin
                            state_d  = HUNT;
                            hvalid_d = 3'd0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            hist_q      <= '0;
            hvalid_q    <= '0;
            pair_q      <= '0;
            byte_q      <= '0;
            phase_q     <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            hvalid_q    <= hvalid_d;
            pair_q      <= pair_d;
            byte_q      <= byte_d;
            phase_q     <= phase_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sof_q       <= sof_d;
            done_q      <= done_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign sof        = sof_q;
    assign frame_done = done_q;
    assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_ddr_deserializer.sv
// Bench for ddr_deserializer: a fixed vector table plus bit-stream driven
// sequences checked against a queue-based frame model.
module tb_ddr_deserializer;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         FLEN = 4;

    logic       clk = 1'b0;
    logic       rst, in_valid, d_rise, d_fall;
    logic [7:0] out_data;
    logic       out_valid, sof, frame_done, locked;

    ddr_deserializer #(.SYNC_WORD(SYNC), .FRAME_LEN(FLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .d_rise(d_rise), .d_fall(d_fall),
        .out_data(out_data), .out_valid(out_valid), .sof(sof),
        .frame_done(frame_done), .locked(locked)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int strobes = 0;
    int lock_seen = 0;

    typedef struct {
        bit [1:0] pr;
        bit [3:0] fl;   // {out_valid, sof, frame_done, locked}
        bit [7:0] dat;
    } vec_t;
    vec_t tbl[20];
    bit [1:0] pl[20] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10,
                         2'b00, 2'b11, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10,
                         2'b01, 2'b11, 2'b10, 2'b00};
    bit [3:0] fl[20] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'hD,
                         4'h1, 4'h1, 4'h1, 4'h9, 4'h1, 4'h1, 4'h1, 4'h9,
                         4'h1, 4'h1, 4'h1, 4'hA};
    bit [7:0] dl[20] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12,
                         8'h12, 8'h12, 8'h12, 8'h34, 8'h34, 8'h34, 8'h34, 8'h56,
                         8'h56, 8'h56, 8'h56, 8'h78};

    // Reference model: a bit queue searched for SYNC while hunting, then a
    // payload bit queue emptied eight bits at a time.
    bit         hq[$];
    bit         pq[$];
    bit         m_lock = 1'b0;
    bit         e_val = 1'b0, e_sof = 1'b0, e_done = 1'b0;
    logic [7:0] e_dat = 8'h00;
    int         m_cnt = 0;
    int         m_emits = 0;

    function automatic logic [7:0] win(int s);
        logic [7:0] w = 8'h00;
        for (int k = 0; k < 8; k++) w = {w[6:0], hq[s + k]};
        return w;
    endfunction

    task automatic model_step(input bit r_st, input bit v, input bit r, input bit f);
        int n;
        logic [7:0] b;
        bit t;
        e_val = 1'b0; e_sof = 1'b0; e_done = 1'b0;
        if (r_st) begin
            hq.delete(); pq.delete();
            m_lock = 1'b0; m_cnt = 0; e_dat = 8'h00;
            return;
        end
        if (!v) return;
        if (!m_lock) begin
            hq.push_back(r); hq.push_back(f);
            n = hq.size();
            if (n >= 10 && win(n - 9) == SYNC) begin
                m_lock = 1'b1; m_cnt = 0; pq.delete(); pq.push_back(f); hq.delete();
            end else if (n >= 8 && win(n - 8) == SYNC) begin
                m_lock = 1'b1; m_cnt = 0; pq.delete(); hq.delete();
            end
            while (hq.size() > 12) t = hq.pop_front();
        end else begin
            pq.push_back(r); pq.push_back(f);
            if (pq.size() >= 8) begin
                b = 8'h00;
                for (int k = 0; k < 8; k++) begin
                    t = pq.pop_front();
                    b = {b[6:0], t};
                end
                e_val = 1'b1; e_dat = b;
                e_sof = (m_cnt == 0);
                e_done = (m_cnt == FLEN - 1);
                m_cnt++; m_emits++;
                if (e_done) begin
                    m_lock = 1'b0; pq.delete(); hq.delete();
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r_st, input bit v, input bit r, input bit f);
        rst = r_st; in_valid = v; d_rise = r; d_fall = f;
        model_step(r_st, v, r, f);
        @(negedge clk);
        chk("flags", {28'd0, out_valid, sof, frame_done, locked}, {28'd0, e_val, e_sof, e_done, m_lock});
        chk("data", {24'd0, out_data}, {24'd0, e_dat});
        if (out_valid) strobes++;
        if (locked) lock_seen++;
    endtask

    task automatic send_bytes(input logic [7:0] bs[$], input int lead, input int gap, input int stop_pairs);
        bit bits[$];
        int p;
        for (int i = 0; i < lead; i++) bits.push_back(1'b0);
        foreach (bs[i]) for (int k = 7; k >= 0; k--) bits.push_back(bs[i][k]);
        if (bits.size() % 2 != 0) bits.push_back(1'b0);
        p = 0;
        while (p * 2 < bits.size()) begin
            if (stop_pairs >= 0 && p == stop_pairs) break;
            if (int'($urandom_range(99)) < gap)
                cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom));
            else begin
                cyc(1'b0, 1'b1, bits[2 * p], bits[2 * p + 1]);
                p++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 20; i++) begin
            tbl[i].pr = pl[i]; tbl[i].fl = fl[i]; tbl[i].dat = dl[i];
        end

        // reset with in_valid high: reset must win
        rst = 1'b1; in_valid = 1'b1; d_rise = 1'b1; d_fall = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("reset_flags", {28'd0, out_valid, sof, frame_done, locked}, 32'd0);
        chk("reset_data", {24'd0, out_data}, 32'd0);

        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; d_rise = tbl[i].pr[1]; d_fall = tbl[i].pr[0];
            @(negedge clk);
            chk($sformatf("vec%0d_flags", i), {28'd0, out_valid, sof, frame_done, locked}, {28'd0, tbl[i].fl});
            chk($sformatf("vec%0d_data", i), {24'd0, out_data}, {24'd0, tbl[i].dat});
        end

        // odd alignment: one leading zero bit
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        strobes = 0;
        send_bytes('{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78}, 1, 0, -1);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("odd_count", strobes, 4);

        // in_valid gaps
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        strobes = 0;
        send_bytes('{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78}, 0, 35, -1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("gap_count", strobes, 4);

        // SYNC-valued payload is plain data
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        strobes = 0; lock_seen = 0;
        send_bytes('{8'hA5, 8'hA5, 8'hA5, 8'h00, 8'hFF}, 0, 0, -1);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("a5_count", strobes, 4);
        chk("a5_lock_cycles", lock_seen, 16);

        // reset after two payload bytes
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        strobes = 0;
        send_bytes('{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78}, 0, 0, 12);
        chk("pre_reset_count", strobes, 2);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        send_bytes('{8'h56, 8'h78}, 0, 0, -1);
        chk("post_reset_count", strobes, 2);

        // noise
        strobes = 0; lock_seen = 0;
        repeat (64) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("noise_strobes", strobes, 0);
        chk("noise_locked", lock_seen, 0);

        // random traffic with occasional embedded frames
        strobes = 0; m_emits = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39) == 0)
                send_bytes('{SYNC, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)},
                           int'($urandom_range(1)), 10, -1);
            else
                cyc(1'b0, 1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom));
        end
        chk("rand_strobes", strobes, m_emits);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
